seq_datapath: RTL and testbench

SEQ_DATAPATH -- requirements
Module: seq_datapath

---
 rtl/seq_datapath_pkg.sv | 36 +++
 rtl/seq_alu.sv | 51 +++++
 rtl/seq_datapath.sv | 145 ++++++++++++++
 tb/tb_seq_datapath.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_datapath_pkg.sv
// Shared definitions for the sequential datapath: opcodes, FSM states, flag bit positions.
package seq_datapath_pkg;

  // Instruction opcodes
  typedef enum logic [2:0] {
    OP_MV  = 3'd0,
    OP_MVI = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_CMP = 3'd7
  } op_e;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Bit positions inside the {N,Z,C,V} flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Moves complete in T1 and never touch the ALU or the flags
  function automatic logic is_move(input op_e op);
    return (op == OP_MV) || (op == OP_MVI);
  endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU: add/sub/logic with {N,Z,C,V} flag generation.
module seq_alu
  import seq_datapath_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic            carry;
  logic            ovf;

  // Compute the result plus carry/overflow; SUB/CMP add the two's complement so carry means "no borrow"
  always_comb begin
    sum    = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[MSB:0];
        carry  = sum[DATA_W];
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result = sum[MSB:0];
        carry  = sum[DATA_W];
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = b;
    endcase
    flags         = 4'b0000;
    flags[FLAG_N] = result[MSB];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/seq_datapath.sv
// Multi-cycle register-machine datapath: IR latch, A/G staging registers, register file and ALU.
module seq_datapath
  import seq_datapath_pkg::*;
#(
  parameter  int DATA_W    = 16,
  parameter  int NUM_REGS  = 8,
  localparam int REG_SEL_W = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [REG_SEL_W-1:0] in_rx,
  input  logic [REG_SEL_W-1:0] in_ry,
  input  logic [DATA_W-1:0]    in_imm,
  output logic                 done,
  output logic                 busy,
  output logic [3:0]           flags,
  input  logic [REG_SEL_W-1:0] rd_sel,
  output logic [DATA_W-1:0]    rd_data
);

  state_e               state_q, state_d;
  op_e                  ir_op_q, ir_op_d;
  logic [REG_SEL_W-1:0] ir_rx_q, ir_rx_d;
  logic [REG_SEL_W-1:0] ir_ry_q, ir_ry_d;
  logic [DATA_W-1:0]    ir_imm_q, ir_imm_d;
  logic [DATA_W-1:0]    a_q, a_d;
  logic [DATA_W-1:0]    g_q, g_d;
  logic [3:0]           flags_q, flags_d;

  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];

  logic                 wr_en;
  logic [DATA_W-1:0]    wr_data;
  logic [DATA_W-1:0]    alu_result;
  logic [3:0]           alu_flags;

  // Second operand always comes from the IR's ry register; A was captured from rx in T1
  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_q),
    .b      (regs_q[ir_ry_q]),
    .op     (ir_op_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Next-state and datapath control; every register holds unless its state acts on it
  always_comb begin
    state_d  = state_q;
    ir_op_d  = ir_op_q;
    ir_rx_d  = ir_rx_q;
    ir_ry_d  = ir_ry_q;
    ir_imm_d = ir_imm_q;
    a_d      = a_q;
    g_d      = g_q;
    flags_d  = flags_q;
    wr_en    = 1'b0;
    wr_data  = g_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ir_op_d  = op_e'(in_op);
          ir_rx_d  = in_rx;
          ir_ry_d  = in_ry;
          ir_imm_d = in_imm;
          state_d  = ST_T1;
        end
      end
      ST_T1: begin
        if (is_move(ir_op_q)) begin
          wr_en   = 1'b1;
          wr_data = (ir_op_q == OP_MVI) ? ir_imm_q : regs_q[ir_ry_q];
          state_d = ST_DONE;
        end else begin
          a_d     = regs_q[ir_rx_q];
          state_d = ST_T2;
        end
      end
      ST_T2: begin
        g_d     = alu_result;
        flags_d = alu_flags;
        state_d = (ir_op_q == OP_CMP) ? ST_DONE : ST_T3;
      end
      ST_T3: begin
        wr_en   = 1'b1;
        wr_data = g_q;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Register-file next value: single write port driven from T1 (moves) or T3 (ALU writeback)
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[ir_rx_q] = wr_data;
    end
  end

  // Control and staging registers; reset aborts any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ir_op_q  <= OP_MV;
      ir_rx_q  <= '0;
      ir_ry_q  <= '0;
      ir_imm_q <= '0;
      a_q      <= '0;
      g_q      <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ir_op_q  <= ir_op_d;
      ir_rx_q  <= ir_rx_d;
      ir_ry_q  <= ir_ry_d;
      ir_imm_q <= ir_imm_d;
      a_q      <= a_d;
      g_q      <= g_d;
      flags_q  <= flags_d;
    end
  end

  // Register file storage, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign flags    = flags_q;
  assign rd_data  = regs_q[rd_sel];

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: directed scenarios plus random instructions against a reference model.
module tb_seq_datapath;

  localparam int DW   = 16;
  localparam int NR   = 8;
  localparam int RSW  = 3;
  localparam int MASK = 32'h0000_FFFF;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     in_op;
  logic [RSW-1:0] in_rx;
  logic [RSW-1:0] in_ry;
  logic [DW-1:0]  in_imm;
  logic           done;
  logic           busy;
  logic [3:0]     flags;
  logic [RSW-1:0] rd_sel;
  logic [DW-1:0]  rd_data;

  int checks = 0;
  int errors = 0;

  // Reference architectural state
  int m_regs [NR];
  int m_flags;

  seq_datapath #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rx    (in_rx),
    .in_ry    (in_ry),
    .in_imm   (in_imm),
    .done     (done),
    .busy     (busy),
    .flags    (flags),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed16(input int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Architectural effect of one instruction, computed with plain integer arithmetic
  function automatic void model_exec(input int op, input int rx, input int ry, input int imm);
    int a, b, r, res, sr, n, z, c, v;
    a = m_regs[rx];
    b = m_regs[ry];
    c = 0;
    v = 0;
    res = 0;
    if (op == 0) begin
      m_regs[rx] = b;
      return;
    end
    if (op == 1) begin
      m_regs[rx] = imm & MASK;
      return;
    end
    case (op)
      2: begin
        r   = a + b;
        res = r & MASK;
        c   = (r > MASK) ? 1 : 0;
        sr  = to_signed16(a) + to_signed16(b);
        v   = (sr > 32767 || sr < -32768) ? 1 : 0;
      end
      3, 7: begin
        r   = a - b;
        res = r & MASK;
        c   = (a >= b) ? 1 : 0;
        sr  = to_signed16(a) - to_signed16(b);
        v   = (sr > 32767 || sr < -32768) ? 1 : 0;
      end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      default: res = 0;
    endcase
    n = (res >= 32768) ? 1 : 0;
    z = (res == 0) ? 1 : 0;
    m_flags = n * 8 + z * 4 + c * 2 + v;
    if (op != 7) m_regs[rx] = res;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 0;
    m_flags = 0;
  endfunction

  function automatic int op_latency(input int op);
    if (op <= 1) return 2;
    if (op == 7) return 3;
    return 4;
  endfunction

  // Counts edges from the accept edge until done is seen, bounded
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Issue one instruction from IDLE and check latency, handshake, flags, writeback
  task automatic issue(input int op, input int rx, input int ry, input int imm);
    int n;
    check("ready_idle", {31'b0, in_ready}, 1);
    in_valid = 1'b1;
    in_op    = op[2:0];
    in_rx    = rx[RSW-1:0];
    in_ry    = ry[RSW-1:0];
    in_imm   = imm[DW-1:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("ready_t1", {31'b0, in_ready}, 0);
    check("busy_t1", {31'b0, busy}, 1);
    wait_done(n);
    model_exec(op, rx, ry, imm);
    check("latency", n, op_latency(op));
    check("ready_done", {31'b0, in_ready}, 0);
    check("flags", {28'b0, flags}, m_flags);
    rd_sel = rx[RSW-1:0];
    #1;
    check("rd_rx", {16'b0, rd_data}, m_regs[rx]);
    $display("op=%0d rx=%0d ry=%0d imm=%04h lat=%0d rd=%04h flags=%04b", op, rx, ry, imm & MASK, n, rd_data, flags);
    @(posedge clk); #1;
    check("done_pulse", {31'b0, done}, 0);
    check("ready_after", {31'b0, in_ready}, 1);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_idle_after_reset();
    check("rst_ready", {31'b0, in_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_flags", {28'b0, flags}, 0);
    check("rst_g", {16'b0, dut.g_q}, 0);
    for (int r = 0; r < NR; r++) begin
      rd_sel = r[RSW-1:0];
      #1;
      check("rst_reg", {16'b0, rd_data}, 0);
    end
  endtask

  initial begin
    int n;
    int seen;
    int imm_tbl [5];
    rst      = 1'b1;
    in_valid = 1'b0;
    in_op    = '0;
    in_rx    = '0;
    in_ry    = '0;
    in_imm   = '0;
    rd_sel   = '0;
    imm_tbl[0] = 0; imm_tbl[1] = 1; imm_tbl[2] = 32'h7FFF; imm_tbl[3] = 32'h8000; imm_tbl[4] = 32'hFFFF;
    model_reset();
    @(posedge clk); #1;
    apply_reset();
    check_idle_after_reset();

    // MVI R3,0x1234
    issue(1, 3, 0, 32'h1234);
    check("mvi_flags", {28'b0, flags}, 4'b0000);
    rd_sel = 3'd3; #1;
    check("mvi_r3", {16'b0, rd_data}, 32'h1234);

    // ADD wrap to zero
    issue(1, 1, 0, 32'hFFFF);
    issue(1, 2, 0, 32'h0001);
    issue(2, 1, 2, 0);
    check("add_flags", {28'b0, flags}, 4'b0110);
    rd_sel = 3'd1; #1;
    check("add_r1", {16'b0, rd_data}, 0);

    // SUB signed overflow, then CMP equal
    issue(1, 1, 0, 32'h8000);
    issue(2 - 1, 2, 0, 32'h0001);
    issue(3, 1, 2, 0);
    check("sub_flags", {28'b0, flags}, 4'b0011);
    rd_sel = 3'd1; #1;
    check("sub_r1", {16'b0, rd_data}, 32'h7FFF);
    issue(1, 4, 0, 5);
    issue(1, 5, 0, 5);
    issue(7, 4, 5, 0);
    check("cmp_flags", {28'b0, flags}, 4'b0110);
    rd_sel = 3'd4; #1;
    check("cmp_r4", {16'b0, rd_data}, 5);

    // Reset during T2 of ADD R6,R7 aborts the instruction
    issue(1, 6, 0, 3);
    issue(1, 7, 0, 4);
    in_valid = 1'b1; in_op = 3'd2; in_rx = 3'd6; in_ry = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("abort_in_t2", {31'b0, busy}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_idle_after_reset();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    rd_sel = 3'd6; #1;
    check("abort_r6", {16'b0, rd_data}, 0);
    $display("reset abort during ADD R6,R7: r6=%04h busy=%0d", rd_data, busy);

    // in_valid held across MVI R2,7 then ADD R2,R2
    in_valid = 1'b1; in_op = 3'd1; in_rx = 3'd2; in_ry = 3'd0; in_imm = 16'd7;
    @(posedge clk); #1;
    in_op = 3'd2; in_rx = 3'd2; in_ry = 3'd2; in_imm = 16'hDEAD;
    wait_done(n);
    model_exec(1, 2, 0, 7);
    check("held_mvi_lat", n, 2);
    rd_sel = 3'd2; #1;
    check("held_mvi_r2", {16'b0, rd_data}, 7);
    @(posedge clk); #1;
    check("held_idle_ready", {31'b0, in_ready}, 1);
    check("held_idle_done", {31'b0, done}, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("held_accept", {31'b0, busy}, 1);
    wait_done(n);
    model_exec(2, 2, 2, 0);
    check("held_add_lat", n, 4);
    rd_sel = 3'd2; #1;
    check("held_add_r2", {16'b0, rd_data}, 14);
    check("held_add_flags", {28'b0, flags}, m_flags);
    $display("held in_valid: MVI R2,7 then ADD R2,R2 -> r2=%04h flags=%04b", rd_data, flags);
    @(posedge clk); #1;
    issue(0, 2, 2, 0);
    rd_sel = 3'd2; #1;
    check("mv_self_r2", {16'b0, rd_data}, 14);

    // Random instruction stream
    for (int t = 0; t < 60; t++) begin
      int op, rx, ry, imm;
      op = $urandom_range(0, 7);
      rx = $urandom_range(0, NR - 1);
      ry = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 1) == 1) imm = imm_tbl[$urandom_range(0, 4)];
      else imm = $urandom_range(0, 65535);
      issue(op, rx, ry, imm);
    end

    for (int r = 0; r < NR; r++) begin
      rd_sel = r[RSW-1:0];
      #1;
      check("final_reg", {16'b0, rd_data}, m_regs[r]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
